// File: rtl/nop_gearbox_pkg.sv
// Shared types and width helpers for the flit <-> lane gearbox.
package nop_gearbox_pkg;

  typedef enum logic {StIdle, StSend} ser_state_e;

  // Beat counter width: at least one bit, even for RATIO of 1 or 2.
  function automatic int unsigned cnt_width(int unsigned ratio);
    return (ratio > 2) ? $clog2(ratio) : 1;
  endfunction

  function automatic int unsigned lane_width(int unsigned data_width, int unsigned ratio);
    return data_width / ratio;
  endfunction

  // Left-shift that brings beat `beat` into the top LANE_WIDTH bits of a flit.
  function automatic int unsigned beat_shift(int unsigned beat, int unsigned lane_w);
    return beat * lane_w;
  endfunction

endpackage

// File: rtl/gearbox_des.sv
// Lane-to-flit deserialiser: RATIO lane beats, MSB first, into one registered flit.
module gearbox_des
  import nop_gearbox_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 130,
  parameter int unsigned RATIO      = 2,
  localparam int unsigned LANE_WIDTH = lane_width(DATA_WIDTH, RATIO),
  localparam int unsigned CNT_W      = cnt_width(RATIO)
) (
  input  logic                  CDCLK,
  input  logic                  CDRESETn,
  input  logic                  sync_clr,
  input  logic [LANE_WIDTH-1:0] lane_data,
  input  logic                  lane_valid,
  output logic                  lane_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      rx_cnt
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0]      rx_cnt_q;
  logic [DATA_WIDTH-1:0] rx_shift_q;
  logic [DATA_WIDTH-1:0] rx_next;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_valid_q;
  logic                  last_beat;
  logic                  accept;

  // Older beats fall off the top, so no clear is needed between flits.
  assign rx_next    = (rx_shift_q << LANE_WIDTH) | DATA_WIDTH'(lane_data);
  assign last_beat  = (rx_cnt_q == LastCnt);
  assign lane_ready = ~sync_clr & (~last_beat | ~out_valid_q | out_ready);
  assign accept     = lane_valid & lane_ready;

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign rx_cnt    = rx_cnt_q;

  always_ff @(posedge CDCLK or negedge CDRESETn) begin
    if (!CDRESETn) begin
      rx_cnt_q    <= '0;
      rx_shift_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (sync_clr) begin
        rx_cnt_q <= '0;
      end else if (accept) begin
        rx_shift_q <= rx_next;
        if (last_beat) begin
          out_data_q  <= rx_next;
          out_valid_q <= 1'b1;
          rx_cnt_q    <= '0;
        end else begin
          rx_cnt_q <= rx_cnt_q + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/gearbox_ser.sv
// Flit-to-lane serialiser: one wide flit out as RATIO lane beats, MSB slice first.
module gearbox_ser
  import nop_gearbox_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 130,
  parameter int unsigned RATIO      = 2,
  localparam int unsigned LANE_WIDTH = lane_width(DATA_WIDTH, RATIO),
  localparam int unsigned CNT_W      = cnt_width(RATIO)
) (
  input  logic                  CDCLK,
  input  logic                  CDRESETn,
  input  logic                  sync_clr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [LANE_WIDTH-1:0] lane_data,
  output logic                  lane_valid,
  input  logic                  lane_ready,
  output logic                  busy
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(RATIO - 1);

  ser_state_e            state_q;
  logic [CNT_W-1:0]      tx_cnt_q;
  logic [DATA_WIDTH-1:0] tx_hold_q;
  logic [DATA_WIDTH-1:0] tx_shifted;
  logic                  last_beat;
  logic                  beat_hs;
  logic                  accept;

  assign busy       = (state_q == StSend);
  assign lane_valid = busy;
  assign last_beat  = (tx_cnt_q == LastCnt);
  assign beat_hs    = busy & lane_ready;
  // A new flit may load on the cycle its predecessor's last beat leaves.
  assign in_ready   = ~sync_clr & (~busy | (lane_ready & last_beat));
  assign accept     = in_valid & in_ready;

  assign tx_shifted = tx_hold_q << beat_shift(32'(tx_cnt_q), LANE_WIDTH);
  assign lane_data  = tx_shifted[DATA_WIDTH-1 -: LANE_WIDTH];

  always_ff @(posedge CDCLK or negedge CDRESETn) begin
    if (!CDRESETn) begin
      state_q   <= StIdle;
      tx_cnt_q  <= '0;
      tx_hold_q <= '0;
    end else if (sync_clr) begin
      state_q  <= StIdle;
      tx_cnt_q <= '0;
    end else if (accept) begin
      tx_hold_q <= in_data;
      tx_cnt_q  <= '0;
      state_q   <= StSend;
    end else if (beat_hs) begin
      if (last_beat) begin
        state_q  <= StIdle;
        tx_cnt_q <= '0;
      end else begin
        tx_cnt_q <= tx_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/nop_gearbox.sv
// Wide flit <-> narrow lane gearbox in the CDCLK domain; SYNC_CLR fan-out and status only.
module nop_gearbox
  import nop_gearbox_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 130,
  parameter int unsigned RATIO      = 2,
  localparam int unsigned LANE_WIDTH = lane_width(DATA_WIDTH, RATIO),
  localparam int unsigned CNT_W      = cnt_width(RATIO)
) (
  input  logic                  CDCLK,
  input  logic                  CDRESETn,
  input  logic                  SYNC_CLR,
  input  logic [DATA_WIDTH-1:0] INDATA,
  input  logic                  INVALID,
  output logic                  INREADY,
  output logic [LANE_WIDTH-1:0] CPODATA,
  output logic                  CPOVALID,
  input  logic                  CPOREADY,
  input  logic [LANE_WIDTH-1:0] CPIDATA,
  input  logic                  CPIVALID,
  output logic                  CPIREADY,
  output logic [DATA_WIDTH-1:0] OUTDATA,
  output logic                  OUTVALID,
  input  logic                  OUTREADY,
  output logic                  TX_BUSY,
  output logic [CNT_W-1:0]      RX_CNT
);

  if ((RATIO == 0) || ((DATA_WIDTH % RATIO) != 0)) begin : g_bad_ratio
    $error("nop_gearbox: DATA_WIDTH must be a non-zero multiple of RATIO");
  end

  gearbox_ser #(
    .DATA_WIDTH (DATA_WIDTH),
    .RATIO      (RATIO)
  ) u_ser (
    .CDCLK      (CDCLK),
    .CDRESETn   (CDRESETn),
    .sync_clr   (SYNC_CLR),
    .in_data    (INDATA),
    .in_valid   (INVALID),
    .in_ready   (INREADY),
    .lane_data  (CPODATA),
    .lane_valid (CPOVALID),
    .lane_ready (CPOREADY),
    .busy       (TX_BUSY)
  );

  gearbox_des #(
    .DATA_WIDTH (DATA_WIDTH),
    .RATIO      (RATIO)
  ) u_des (
    .CDCLK      (CDCLK),
    .CDRESETn   (CDRESETn),
    .sync_clr   (SYNC_CLR),
    .lane_data  (CPIDATA),
    .lane_valid (CPIVALID),
    .lane_ready (CPIREADY),
    .out_data   (OUTDATA),
    .out_valid  (OUTVALID),
    .out_ready  (OUTREADY),
    .rx_cnt     (RX_CNT)
  );

endmodule
